// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter
//  Brief    : Round-robin arbiter sharing one byte-enable RAM port between
//             the UART bridge (req0) and the accelerator DMA (req1). Drives
//             the RAM from the granted request and returns registered read
//             data to the requester that issued the read one cycle later.
//             Optional grant locking is compiled in with RAM_ARB_LOCK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int LINES           = 8192,
    parameter int XLEN            = 32,
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [$clog2(LINES)-1:0] req0_addr,
    input  logic [XLEN/8-1:0]        req0_be,
    input  logic [XLEN-1:0]          req0_wdata,
    output logic                     req0_rvalid,
    output logic [XLEN-1:0]          req0_rdata,
`ifdef RAM_ARB_LOCK_EN
    input  logic                     req0_lock,
`endif

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [$clog2(LINES)-1:0] req1_addr,
    input  logic [XLEN/8-1:0]        req1_be,
    input  logic [XLEN-1:0]          req1_wdata,
    output logic                     req1_rvalid,
    output logic [XLEN-1:0]          req1_rdata,
`ifdef RAM_ARB_LOCK_EN
    input  logic                     req1_lock,
`endif

    output logic [$clog2(LINES)-1:0] ram_addr,
    output logic                     ram_en,
    output logic [XLEN/8-1:0]        ram_be,
    output logic [XLEN-1:0]          ram_data_in,
    input  logic [XLEN-1:0]          ram_data_out
);

    localparam int c_AW  = $clog2(LINES);
    localparam int c_BEW = XLEN / 8;

    // Arbitration state and read-response tracking
    logic              r_last_grant;
    logic              r_rd_pending;
    logic              r_rd_owner;
    logic [c_AW-1:0]   r_addr_hold;

    // Grant decision and the multiplexed granted request
    logic [1:0]        w_valid;
    logic              w_hold;
    logic              w_grant;
    logic              w_idx;
    logic [c_AW-1:0]   w_sel_addr;
    logic [c_BEW-1:0]  w_sel_be;
    logic [XLEN-1:0]   w_sel_wdata;
    logic              w_sel_read;

    assign w_valid = {req1_valid, req0_valid};

`ifdef RAM_ARB_LOCK_EN
    localparam int c_LCW = $clog2(MAX_LOCK_CYCLES + 1);

    logic [1:0]        w_lock;
    logic              w_sel_lock;
    logic [c_LCW-1:0]  r_lock_cnt;

    assign w_lock     = {req1_lock, req0_lock};
    assign w_sel_lock = w_idx ? req1_lock : req0_lock;

    // The previous owner keeps the port while its locked streak is below
    // the limit and it is still asking with lock held. A non-zero count
    // means the last transfer was a locked one by r_last_grant.
    assign w_hold = (r_lock_cnt != '0)
                 && (r_lock_cnt < c_LCW'(MAX_LOCK_CYCLES))
                 && w_valid[r_last_grant]
                 && w_lock[r_last_grant];

    // Locked-streak counter: restarts at 1 on a fresh locked grant, clears
    // on any unlocked grant. Once the limit is reached w_hold drops, so the
    // plain round-robin below hands the port to the other side if it waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_cnt <= '0;
        end else if (w_grant) begin
            if (!w_sel_lock) begin
                r_lock_cnt <= '0;
            end else if ((w_idx == r_last_grant) && (r_lock_cnt != '0)
                         && (r_lock_cnt < c_LCW'(MAX_LOCK_CYCLES))) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end else begin
                r_lock_cnt <= c_LCW'(1);
            end
        end
    end
`else
    // Lock limit has no effect when locking is not built in
    if (MAX_LOCK_CYCLES < 1) begin : g_lock_limit_unused
    end

    assign w_hold = 1'b0;
`endif

    // Round-robin grant: a lone requester wins, a tie goes to the side that
    // did not win last, and an active lock overrides both.
    always_comb begin
        w_grant = 1'b0;
        w_idx   = 1'b0;
        if (w_hold) begin
            w_grant = 1'b1;
            w_idx   = r_last_grant;
        end else if (w_valid[0] && w_valid[1]) begin
            w_grant = 1'b1;
            w_idx   = ~r_last_grant;
        end else if (w_valid[0]) begin
            w_grant = 1'b1;
            w_idx   = 1'b0;
        end else if (w_valid[1]) begin
            w_grant = 1'b1;
            w_idx   = 1'b1;
        end
    end

    assign w_sel_addr  = w_idx ? req1_addr  : req0_addr;
    assign w_sel_be    = w_idx ? req1_be    : req0_be;
    assign w_sel_wdata = w_idx ? req1_wdata : req0_wdata;
    assign w_sel_read  = (w_sel_be == '0);

    // Ready goes only to the granted side, so at most one is high
    assign req0_ready = w_grant && !w_idx;
    assign req1_ready = w_grant &&  w_idx;

    // RAM drive: pass the granted request through; with no grant the address
    // stays on the last granted word and nothing is written.
    always_comb begin
        ram_addr    = r_addr_hold;
        ram_be      = '0;
        ram_data_in = '0;
        ram_en      = 1'b0;
        if (w_grant) begin
            ram_addr    = w_sel_addr;
            ram_be      = w_sel_be;
            ram_data_in = w_sel_wdata;
            ram_en      = !w_sel_read;
        end
    end

    // Round-robin pointer, held address and one-cycle read-response flag.
    // The RAM registers its output on the transfer edge, so its data lines
    // up with r_rd_pending in the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= 1'b0;
            r_addr_hold  <= '0;
        end else begin
            r_rd_pending <= w_grant && w_sel_read;
            if (w_grant) begin
                r_last_grant <= w_idx;
                r_addr_hold  <= w_sel_addr;
                if (w_sel_read) begin
                    r_rd_owner <= w_idx;
                end
            end
        end
    end

    // Steer the read response to whoever issued it; data is zero otherwise
    assign req0_rvalid = r_rd_pending && !r_rd_owner;
    assign req1_rvalid = r_rd_pending &&  r_rd_owner;
    assign req0_rdata  = req0_rvalid ? ram_data_out : '0;
    assign req1_rdata  = req1_rvalid ? ram_data_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_port_arbiter
//  Brief    : Self-checking bench for ram_port_arbiter with a byte-enable RAM
//             model that registers its read data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int LINES = 8192;
    localparam int XLEN  = 32;
    localparam int AW    = 13;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req0_ready, req0_rvalid;
    logic [AW-1:0]   req0_addr;
    logic [3:0]      req0_be;
    logic [31:0]     req0_wdata, req0_rdata;
    logic            req1_valid, req1_ready, req1_rvalid;
    logic [AW-1:0]   req1_addr;
    logic [3:0]      req1_be;
    logic [31:0]     req1_wdata, req1_rdata;
    logic [AW-1:0]   ram_addr;
    logic            ram_en;
    logic [3:0]      ram_be;
    logic [31:0]     ram_data_in;
    logic [31:0]     ram_data_out;
`ifdef RAM_ARB_LOCK_EN
    logic            req0_lock, req1_lock;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .LINES           (LINES),
        .XLEN            (XLEN),
        .MAX_LOCK_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_be      (req0_be),
        .req0_wdata   (req0_wdata),
        .req0_rvalid  (req0_rvalid),
        .req0_rdata   (req0_rdata),
`ifdef RAM_ARB_LOCK_EN
        .req0_lock    (req0_lock),
`endif
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_be      (req1_be),
        .req1_wdata   (req1_wdata),
        .req1_rvalid  (req1_rvalid),
        .req1_rdata   (req1_rdata),
`ifdef RAM_ARB_LOCK_EN
        .req1_lock    (req1_lock),
`endif
        .ram_addr     (ram_addr),
        .ram_en       (ram_en),
        .ram_be       (ram_be),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // Byte-enable RAM with registered (read-before-write) output
    logic [31:0] mem [0:LINES-1];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_en && ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_data_in[b*8 +: 8];
        end
        ram_data_out <= mem[ram_addr];
    end

    typedef struct {
        logic v0; logic [AW-1:0] a0; logic [3:0] be0; logic [31:0] d0;
        logic v1; logic [AW-1:0] a1; logic [3:0] be1; logic [31:0] d1;
        logic r0; logic r1; logic en; logic [3:0] be; logic [AW-1:0] addr; logic [31:0] din;
        logic rv0; logic rv1; logic [31:0] rd0; logic [31:0] rd1;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(
        input logic v0, input logic [AW-1:0] a0, input logic [3:0] be0, input logic [31:0] d0,
        input logic v1, input logic [AW-1:0] a1, input logic [3:0] be1, input logic [31:0] d1,
        input logic r0, input logic r1, input logic en, input logic [3:0] be,
        input logic [AW-1:0] addr, input logic [31:0] din,
        input logic rv0, input logic rv1, input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.en = en; v.be = be; v.addr = addr; v.din = din;
        v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_addr = v.a0; req0_be = v.be0; req0_wdata = v.d0;
        req1_valid = v.v1; req1_addr = v.a1; req1_be = v.be1; req1_wdata = v.d1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_addr = '0; req0_be = '0; req0_wdata = '0;
        req1_valid = 0; req1_addr = '0; req1_be = '0; req1_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < LINES; i++) mem[i] = '0;
        rst = 1'b1;
        idle_inputs();
`ifdef RAM_ARB_LOCK_EN
        req0_lock = 1'b0;
        req1_lock = 1'b0;
`endif

        //     v0 a0     be0  d0            v1 a1 be1  d1            r0 r1 en be    addr   din           rv0 rv1 rd0           rd1
        vecs[0]  = mk(1, 'h10, 4'hF, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0,        1, 0, 1, 4'hF, 'h10, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0);
        vecs[1]  = mk(1, 'h10, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        1, 0, 0, 4'h0, 'h10, 32'h0,        0, 0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 0,    4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 0, 4'h0, 'h10, 32'h0,        1, 0, 32'hDEADBEEF, 32'h0);
        vecs[3]  = mk(0, 0,    4'h0, 32'h0,        1, 1, 4'hF, 32'h11110001, 0, 1, 1, 4'hF, 1,    32'h11110001, 0, 0, 32'h0,        32'h0);
        vecs[4]  = mk(1, 2,    4'hF, 32'h22220002, 0, 0, 4'h0, 32'h0,        1, 0, 1, 4'hF, 2,    32'h22220002, 0, 0, 32'h0,        32'h0);
        vecs[5]  = mk(0, 0,    4'h0, 32'h0,        1, 5, 4'hF, 32'h11223344, 0, 1, 1, 4'hF, 5,    32'h11223344, 0, 0, 32'h0,        32'h0);
        vecs[6]  = mk(1, 1,    4'h0, 32'h0,        1, 2, 4'h0, 32'h0,        1, 0, 0, 4'h0, 1,    32'h0,        0, 0, 32'h0,        32'h0);
        vecs[7]  = mk(1, 1,    4'h0, 32'h0,        1, 2, 4'h0, 32'h0,        0, 1, 0, 4'h0, 2,    32'h0,        1, 0, 32'h11110001, 32'h0);
        vecs[8]  = mk(1, 1,    4'h0, 32'h0,        1, 2, 4'h0, 32'h0,        1, 0, 0, 4'h0, 1,    32'h0,        0, 1, 32'h0,        32'h22220002);
        vecs[9]  = mk(1, 1,    4'h0, 32'h0,        1, 2, 4'h0, 32'h0,        0, 1, 0, 4'h0, 2,    32'h0,        1, 0, 32'h11110001, 32'h0);
        vecs[10] = mk(0, 0,    4'h0, 32'h0,        1, 5, 4'h4, 32'h00AA0000, 0, 1, 1, 4'h4, 5,    32'h00AA0000, 0, 1, 32'h0,        32'h22220002);
        vecs[11] = mk(1, 5,    4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        1, 0, 0, 4'h0, 5,    32'h0,        0, 0, 32'h0,        32'h0);
        vecs[12] = mk(0, 0,    4'h0, 32'h0,        1, 1, 4'h0, 32'h0,        0, 1, 0, 4'h0, 1,    32'h0,        1, 0, 32'h11AA3344, 32'h0);
        vecs[13] = mk(0, 0,    4'h0, 32'h0,        1, 2, 4'h0, 32'h0,        0, 1, 0, 4'h0, 2,    32'h0,        0, 1, 32'h0,        32'h11110001);
        vecs[14] = mk(0, 0,    4'h0, 32'h0,        1, 5, 4'h0, 32'h0,        0, 1, 0, 4'h0, 5,    32'h0,        0, 1, 32'h0,        32'h22220002);
        vecs[15] = mk(0, 'h1FFF, 4'hF, 32'hFFFFFFFF, 0, 0, 4'h0, 32'h0,      0, 0, 0, 4'h0, 5,    32'h0,        0, 1, 32'h0,        32'h11AA3344);
        vecs[16] = mk(0, 0,    4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 0, 4'h0, 5,    32'h0,        0, 0, 32'h0,        32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rvalid0", 32'(req0_rvalid), 32'h0);
        check("reset rvalid1", 32'(req1_rvalid), 32'h0);
        check("reset ram_en",  32'(ram_en),      32'h0);
        check("reset ram_addr", 32'(ram_addr),   32'h0);
        check("reset ready0",  32'(req0_ready),  32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table-driven vectors, one per cycle
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d ready0", i),      32'(req0_ready),  32'(vecs[i].r0));
            check($sformatf("v%0d ready1", i),      32'(req1_ready),  32'(vecs[i].r1));
            check($sformatf("v%0d ram_en", i),      32'(ram_en),      32'(vecs[i].en));
            check($sformatf("v%0d ram_be", i),      32'(ram_be),      32'(vecs[i].be));
            check($sformatf("v%0d ram_addr", i),    32'(ram_addr),    32'(vecs[i].addr));
            check($sformatf("v%0d ram_data_in", i), ram_data_in,      vecs[i].din);
            check($sformatf("v%0d rvalid0", i),     32'(req0_rvalid), 32'(vecs[i].rv0));
            check($sformatf("v%0d rvalid1", i),     32'(req1_rvalid), 32'(vecs[i].rv1));
            check($sformatf("v%0d rdata0", i),      req0_rdata,       vecs[i].rd0);
            check($sformatf("v%0d rdata1", i),      req1_rdata,       vecs[i].rd1);
            @(posedge clk);
            #1;
        end

        // Reset while a read is in flight: response dropped, req0 wins after
        idle_inputs();
        req0_valid = 1'b1; req0_addr = 'h10;
        @(negedge clk);
        check("rstmid ready0", 32'(req0_ready), 32'h1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid rvalid0", 32'(req0_rvalid), 32'h0);
        check("rstmid rdata0",  req0_rdata,       32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 1;
        req1_valid = 1'b1; req1_addr = 2;
        @(negedge clk);
        check("post-reset ready0",  32'(req0_ready),  32'h1);
        check("post-reset ready1",  32'(req1_ready),  32'h0);
        check("post-reset rvalid0", 32'(req0_rvalid), 32'h0);
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        check("post-reset read rvalid0", 32'(req0_rvalid), 32'h1);
        check("post-reset read rdata0",  req0_rdata,       32'h11110001);
        check("post-reset read rvalid1", 32'(req1_rvalid), 32'h0);

`ifdef RAM_ARB_LOCK_EN
        // Locked req0 against a waiting req1 with a limit of 4
        begin
            logic [5:0] pat;
            pat = 6'b101111;
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            req0_valid = 1'b1; req0_lock = 1'b1; req0_addr = 0;
            req1_valid = 1'b1; req1_addr = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                check($sformatf("lock c%0d ready0", k), 32'(req0_ready), 32'(pat[k]));
                check($sformatf("lock c%0d ready1", k), 32'(req1_ready), 32'(!pat[k]));
                @(posedge clk);
                #1;
            end
            idle_inputs();
            req0_lock = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of the dual-port byte-enable data RAM between two requesters: the UART bridge (req0) and the hardware accelerator DMA (req1).
- Round-robin arbitration with a valid/ready request channel.
- Drives RAM address, enable, byte-enables and write data for the granted requester.
- Routes the RAM's registered read data back to the requester that issued the read, as a one-cycle-later response.

Parameters:
- LINES, 8192, RAM depth in 32-bit words; address width is $clog2(LINES).
- XLEN, 32, data width from riscv_config; byte-enable width is XLEN/8.
- MAX_LOCK_CYCLES, 16, maximum consecutive grants to one locked requester (used only with RAM_ARB_LOCK_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- req0_valid  input  1  UART bridge request valid
- req0_ready  output  1  req0 accepted this cycle
- req0_addr  input  $clog2(LINES)  word address
- req0_be  input  XLEN/8  byte enables; all-zero means read
- req0_wdata  input  XLEN  write data
- req0_rvalid  output  1  read data valid for req0
- req0_rdata  output  XLEN  read data for req0
- req0_lock  input  1  hold grant (present only with RAM_ARB_LOCK_EN)
- req1_valid, req1_ready, req1_addr, req1_be, req1_wdata, req1_rvalid, req1_rdata, req1_lock  same as req0, for the accelerator DMA
- ram_addr  output  $clog2(LINES)  to RAM addr
- ram_en  output  1  to RAM write enable
- ram_be  output  XLEN/8  to RAM byte enables
- ram_data_in  output  XLEN  to RAM write data
- ram_data_out  input  XLEN  registered RAM read data

Behaviour:
- Reset (async on rst high):
  - last_grant=1, so req0 has first priority.
  - req0_rvalid=0, req1_rvalid=0, rd_owner=0, rd_pending=0, lock_cnt=0.
- Arbitration (combinational, each cycle):
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the requester that is not last_grant.
  - Neither valid: no grant, ram_en=0, ram_be=0.
- Grant handshake:
  - reqN_ready=1 only for the granted requester; at most one ready per cycle.
  - Transfer occurs when reqN_valid & reqN_ready.
  - ready may depend on valid; a requester must hold its address, be and wdata stable while valid && !ready.
- RAM drive, combinational from the granted request:
  - ram_addr = addr.
  - ram_be = be.
  - ram_data_in = wdata.
  - ram_en = 1 if be != 0, else 0.
- With no grant: ram_addr holds the last granted address (registered copy, reset 0), ram_data_in=0.
- last_grant updates to the granted index on every transfer.
- Reads (be==0):
  - On transfer, rd_pending<=1 and rd_owner<=index.
  - Next cycle, reqN_rvalid=1 for rd_owner only, for exactly one cycle.
- Read data:
  - reqN_rdata = ram_data_out when reqN_rvalid, else 0.
  - Read latency is exactly 1 cycle from transfer; back-to-back reads give rvalid every cycle.
- Writes (be!=0): no response; the write is committed at the RAM edge of the transfer cycle.
- Read-after-write to the same address by the next transfer returns the new data. Reads of a word during the cycle it is written are not guaranteed.
- Reset mid-operation: a pending rvalid is dropped; no replay.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- Defined:
  - reqN_lock ports exist.
  - If the current owner transfers with lock=1, it keeps priority while lock && valid, even when the other requester is valid.
  - lock_cnt counts consecutive locked grants. When it reaches MAX_LOCK_CYCLES, the next cycle grants the other requester if it is valid, and lock_cnt resets to 0.
  - lock_cnt resets to 0 on any grant without lock or on an owner change.
- Not defined: no lock ports, no lock_cnt, pure round-robin.

Test Plan:
- Reset, then req0 writes addr 0x10 be=4'b1111 data 0xDEADBEEF; next cycle req0 reads 0x10 -> req0_rvalid=1 one cycle after transfer, req0_rdata=0xDEADBEEF, req1_rvalid=0.
- Both valid for 4 cycles with reads to addr 1 (req0) and addr 2 (req1) -> grants alternate 0,1,0,1; each rvalid/rdata goes to the correct owner.
- Byte-enable merge: write 0x11223344 to addr 5, then req1 writes be=4'b0100 data 0x00AA0000 -> a read of addr 5 returns 0x11AA3344.
- req1 valid while req0 idle for 3 cycles -> req1_ready=1 every cycle; back-to-back read rvalid each cycle; with no request, ram_en=0 and ram_be=0.
- Assert rst while a read is in flight (transfer at cycle N, rst at N+1) -> rvalid=0 immediately; after release, req0 wins first.
- RAM_ARB_LOCK_EN, MAX_LOCK_CYCLES=4: req0 lock=1 continuous, req1 valid -> req0 granted 4 cycles, then req1 granted 1 cycle, then req0 again.
